mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential Booth multiplier (start/done handshake) between N_REQ requesters.
//  - Arbitrates pending requests, latches the winner's operands and pulses the multiplier start.
//  - Waits for done, then returns the 2*WIDTH product with the requester ID on a response port.
//  - A watchdog aborts a hung multiplication.
// PARAMETERS
//  N_REQ    4   number of requesters, 2..8
//  WIDTH    8   operand width (two's complement); product is 2*WIDTH
//  TIMEOUT  64  max cycles in WAIT before abort, >= 4
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              asynchronous reset, active-high
//  req_valid   in   N_REQ          request pending, per requester
//  req_a       in   N_REQ*WIDTH    multiplicand; slice i belongs to requester i
//  req_b       in   N_REQ*WIDTH    multiplier; slice i belongs to requester i
//  req_ready   out  N_REQ          one-hot; operands accepted at this edge
//  mult_valid  out  1              one-cycle start pulse to the multiplier
//  mult_a      out  WIDTH          latched multiplicand
//  mult_b      out  WIDTH          latched multiplier
//  mult_done   in   1              multiplier finished; product valid this cycle
//  mult_p      in   2*WIDTH        multiplier product
//  resp_valid  out  1              response available
//  resp_ready  in   1              consumer accepts response
//  resp_id     out  $clog2(N_REQ)  requester index of the response
//  resp_p      out  2*WIDTH        product; 0 when resp_err=1
//  resp_err    out  1              watchdog abort flag
//  busy        out  1              high in every state except IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE; watchdog counter 0; RR pointer 0.
//  - The multiplier shares rst. Reset mid-operation discards the transaction and sends no response.
//  FSM states:
//  - IDLE: if any req_valid, assert req_ready[g] combinationally for winner g only.
//    At the edge, capture req_a[g]/req_b[g] into mult_a/mult_b and g into resp_id; go to LAUNCH.
//    With no requests, stay in IDLE.
//  - LAUNCH: mult_valid=1 for exactly one cycle; clear the watchdog; go to WAIT.
//  - WAIT: on mult_done=1, register resp_p=mult_p, resp_err=0, resp_valid=1; go to RESP.
//    Otherwise increment the watchdog. When the count reaches TIMEOUT-1 with no done,
//    register resp_p=0, resp_err=1, resp_valid=1; go to RESP.
//    mult_done seen in any other state is ignored.
//  - RESP: hold resp_valid, resp_id, resp_p and resp_err stable until resp_ready=1.
//    At that edge, clear resp_valid and go to IDLE. req_ready stays 0.
//  Latency and throughput:
//  - req_ready to mult_valid: 1 cycle.
//  - mult_done to resp_valid: 1 cycle.
//  - At most one multiplication is in flight. Minimum turnaround is 4 cycles plus multiplier latency.
//  Handshake rules:
//  - A requester holds req_valid and its operands until it sees req_ready.
//  - Deasserting req_valid before grant withdraws the request.
//  Datapath:
//  - Operands pass through unmodified; no sign handling is done here.
// CONFIGURATION
//  MULT_ARB_RR_EN
//  - Defined: round-robin. Search starts at the RR pointer and wraps modulo N_REQ.
//    After each grant g the pointer becomes (g+1) mod N_REQ; N_REQ-1 wraps to 0.
//  - Undefined: fixed priority, lowest index wins. Lower-index requesters may starve higher ones.
// TESTING (N_REQ=4, WIDTH=8, TIMEOUT=64)
//  1. req0 a=5, b=-3, behavioral multiplier model.
//     -> req_ready=0001 for one cycle; mult_valid the next cycle;
//        resp_valid with resp_id=0, resp_p=16'hFFF1, resp_err=0.
//  2. req_valid=1111 held continuously, resp_ready=1.
//     -> grant order 0,1,2,3,0 with RR_EN; 0,0,0,0 without it.
//  3. a=-128, b=-128. -> resp_p=16'h4000.
//  4. resp_ready=0 for 10 cycles after resp_valid.
//     -> resp_* stable; req_ready=0 throughout; IDLE entered one cycle after resp_ready=1.
//  5. mult_done tied 0. -> resp_valid, resp_err=1, resp_p=0 after 64 cycles in WAIT; recovery on next request.
//  6. rst pulsed mid-WAIT. -> all outputs 0 immediately; no response; next request served normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one sequential multiplier and returns the product with a watchdog.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       mult_valid,
    output logic [WIDTH-1:0]           mult_a,
    output logic [WIDTH-1:0]           mult_b,
    input  logic                       mult_done,
    input  logic [2*WIDTH-1:0]         mult_p,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]         resp_p,
    output logic                       resp_err,
    output logic                       busy
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    logic [CW-1:0]    wd_count;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef MULT_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;
    logic [IDW:0]   rr_sum;
`endif
    logic [IDW-1:0] idx;

    // First pending requester in search order, starting at the pointer in round-robin mode
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
`ifdef MULT_ARB_RR_EN
        rr_sum = '0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
`ifdef MULT_ARB_RR_EN
            rr_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(N_REQ))
                rr_sum = rr_sum - (IDW+1)'(N_REQ);
            idx = rr_sum[IDW-1:0];
`else
            idx = IDW'(k);
`endif
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && found && !rst)
            req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wd_count   <= '0;
            mult_valid <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_p     <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
`ifdef MULT_ARB_RR_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        mult_a     <= a_arr[winner];
                        mult_b     <= b_arr[winner];
                        resp_id    <= winner;
                        mult_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_LAUNCH;
`ifdef MULT_ARB_RR_EN
                        rr_ptr     <= (winner == IDW'(N_REQ-1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                ST_LAUNCH: begin
                    mult_valid <= 1'b0;
                    wd_count   <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still wins over the abort
                    if (mult_done) begin
                        resp_p     <= mult_p;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (wd_count == CW'(TIMEOUT-1)) begin
                        resp_p     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized self-checking bench for mult_arbiter with a transaction-level timing model
// and a behavioural multiplier of selectable latency.
module tb_mult_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           mult_valid;
    logic [W-1:0]   mult_a, mult_b;
    logic           mult_done;
    logic [2*W-1:0] mult_p;
    logic           resp_valid, resp_ready;
    logic [1:0]     resp_id;
    logic [2*W-1:0] resp_p;
    logic           resp_err, busy;

    mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_valid(mult_valid), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_p(mult_p),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_p(resp_p), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Requester side
    logic [N-1:0] vld;
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    int           last_grant = -1;

    // Bench controls
    bit auto_req  = 0;
    bit keep_full = 0;
    bit hang      = 0;
    bit resp_rand = 0;
    int fixed_lat = 3;
    int hold_left = 0;

    // Transaction model
    int           cyc = 0;
    bit           txn_busy = 0;
    int           grant_cyc = -1000;
    int           resp_cyc = -1000;
    int           lat = 1;
    int           gid = 0;
    logic [W-1:0] ga, gb, cap_a, cap_b;
    logic [15:0]  exp_p;
    bit           exp_err;
    int           rr_ptr = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa, pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return 16'(pa * pb);
    endfunction

    task automatic apply_reqs();
        req_valid = vld;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    endtask

    task automatic new_req(input int i);
        vld[i]  = 1'b1;
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_req_ready"}, req_ready, 0);
        check_value({tag, "_mult_valid"}, mult_valid, 0);
        check_value({tag, "_mult_a"}, mult_a, 0);
        check_value({tag, "_mult_b"}, mult_b, 0);
        check_value({tag, "_resp_valid"}, resp_valid, 0);
        check_value({tag, "_resp_id"}, resp_id, 0);
        check_value({tag, "_resp_p"}, resp_p, 0);
        check_value({tag, "_resp_err"}, resp_err, 0);
        check_value({tag, "_busy"}, busy, 0);
    endtask

    task automatic step();
        int w;
        @(negedge clk);
        cyc++;
        // Requesters react to last cycle's grant, then optionally raise or withdraw
        for (int i = 0; i < N; i++) begin
            if (last_grant == i) begin
                vld[i] = 1'b0;
                if (keep_full) new_req(i);
            end else if (auto_req) begin
                if (!vld[i] && $urandom_range(0, 3) == 0) new_req(i);
                else if (vld[i] && $urandom_range(0, 40) == 0) vld[i] = 1'b0;
            end
        end
        last_grant = -1;
        apply_reqs();
        // Multiplier: real done after the chosen latency, junk done pulses where they must be ignored
        mult_done = 1'b0;
        mult_p    = 16'($urandom);
        if (txn_busy && !hang && cyc == grant_cyc + 1 + lat) begin
            mult_done = 1'b1;
            mult_p    = smul(cap_a, cap_b);
        end else if ((!txn_busy || cyc <= grant_cyc + 1 || cyc >= resp_cyc) && $urandom_range(0, 7) == 0) begin
            mult_done = 1'b1;
        end
        if (hold_left > 0) begin
            resp_ready = 1'b0;
            if (txn_busy && cyc >= resp_cyc) hold_left--;
        end else begin
            resp_ready = resp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        if (!txn_busy) begin
            w = pick(vld, rr_ptr);
            check_value("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
            check_value("busy_idle", busy, 0);
            check_value("mult_valid_idle", mult_valid, 0);
            check_value("resp_valid_idle", resp_valid, 0);
            if (w >= 0) begin
                txn_busy  = 1;
                gid       = w;
                ga        = op_a[w];
                gb        = op_b[w];
                grant_cyc = cyc;
                last_grant = w;
                if (fixed_lat > 0) lat = fixed_lat;
                else lat = ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(1, 20);
                resp_cyc = hang ? cyc + T + 2 : cyc + lat + 2;
                exp_p    = hang ? 16'h0 : smul(ga, gb);
                exp_err  = hang;
`ifdef MULT_ARB_RR_EN
                rr_ptr = (w + 1) % N;
`endif
            end
        end else begin
            check_value("req_ready_busy", req_ready, 0);
            check_value("busy", busy, 1);
            check_value("mult_valid", mult_valid, (cyc == grant_cyc + 1) ? 1 : 0);
            if (cyc == grant_cyc + 1) begin
                check_value("mult_a", mult_a, ga);
                check_value("mult_b", mult_b, gb);
                cap_a = mult_a;
                cap_b = mult_b;
            end
            check_value("resp_valid", resp_valid, (cyc >= resp_cyc) ? 1 : 0);
            if (cyc >= resp_cyc) begin
                check_value("resp_id", resp_id, gid);
                check_value("resp_p", resp_p, exp_p);
                check_value("resp_err", resp_err, exp_err);
                if (resp_ready) begin
                    $display("txn id=%0d a=%0h b=%0h lat=%0d p=%0h err=%0d", gid, ga, gb,
                             hang ? -1 : lat, resp_p, resp_err);
                    txn_busy = 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse in the low clock phase; the next edge sees no requests
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        vld = '0;
        apply_reqs();
        mult_done = 1'b0;
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b0;
        txn_busy   = 0;
        rr_ptr     = 0;
        last_grant = -1;
        grant_cyc  = -1000;
        resp_cyc   = -1000;
    endtask

    initial begin
        rst        = 1'b1;
        vld        = '1;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        apply_reqs();
        mult_done  = 1'b0;
        mult_p     = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        vld = '0;
        apply_reqs();
        @(negedge clk);
        rst = 1'b0;

        // Single request 5 * -3
        vld[0] = 1'b1; op_a[0] = 8'd5; op_b[0] = 8'hFD;
        run(15);
        // -128 * -128
        vld[2] = 1'b1; op_a[2] = 8'h80; op_b[2] = 8'h80;
        run(15);
        // All four requesting continuously
        keep_full = 1;
        for (int i = 0; i < N; i++) new_req(i);
        run(45);
        keep_full = 0;
        run(40);
        // Consumer stalls for 10 cycles while junk done pulses may arrive
        hold_left = 10;
        new_req(1);
        run(30);
        // Hung multiplier, then recovery
        hang = 1;
        new_req(3);
        run(T + 10);
        hang = 0;
        new_req(0);
        run(15);
        // Done on the final watchdog cycle, and one before it
        fixed_lat = 64;
        new_req(1);
        run(T + 10);
        fixed_lat = 63;
        new_req(2);
        run(T + 10);
        // Reset in the middle of WAIT discards the transaction
        fixed_lat = 40;
        new_req(2);
        run(10);
        pulse_reset();
        fixed_lat = 3;
        new_req(2);
        run(20);
        // Random traffic
        auto_req  = 1;
        resp_rand = 1;
        fixed_lat = 0;
        run(2500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
